// File: rtl/timealign_frame_packer.sv
// Packs aligned words from the time aligner into frames and queues them in a
// small show-ahead FIFO, with a valid/ready output handshake and sticky overflow.
`timescale 1ns/1ps
module timealign_frame_packer #(
    parameter int WORD_W          = 6,
    parameter int WORDS_PER_FRAME = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [WORD_W-1:0]                 din_i,
    input  logic                              din_valid_i,
    input  logic                              flush_i,
    output logic [WORD_W*WORDS_PER_FRAME-1:0] frame_o,
    output logic                              frame_valid_o,
    input  logic                              frame_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]       level_o,
    output logic                              overflow_o
);
    localparam int FW = WORD_W * WORDS_PER_FRAME;
    localparam int CW = $clog2(WORDS_PER_FRAME);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [CW-1:0] wcnt_reg, wcnt_next;
    logic          take, complete;
    logic [FW-1:0] frame_in;

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next, remain;
    logic [FW-1:0] frame_reg, frame_next;
    logic          valid_reg, valid_next, ovf_reg, ovf_next;
    logic          pop, push, full;

    assign take     = din_valid_i && !flush_i;
    assign complete = take && (wcnt_reg == CW'(WORDS_PER_FRAME - 1));

    // Completing word goes straight into the low slice; earlier words come from slice registers.
    assign frame_in[WORD_W-1:0] = din_i;

    genvar gi;
    generate
        for (gi = 1; gi < WORDS_PER_FRAME; gi++) begin : g_slice
            logic [WORD_W-1:0] slice_reg;
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    slice_reg <= '0;
                end else if (take && (wcnt_reg == CW'(WORDS_PER_FRAME - 1 - gi))) begin
                    slice_reg <= din_i;
                end
            end
            assign frame_in[gi*WORD_W +: WORD_W] = slice_reg;
        end
    endgenerate

    always_comb begin
        wcnt_next = wcnt_reg;
        if (flush_i) begin
            wcnt_next = '0;
        end else if (din_valid_i) begin
            wcnt_next = complete ? '0 : wcnt_reg + CW'(1);
        end
    end

    always_comb begin
        pop         = valid_reg && frame_ready_i;
        full        = (level_reg == LW'(FIFO_DEPTH));
        push        = complete && (!full || pop);
        ovf_next    = ovf_reg || (complete && full && !pop);
        level_next  = level_reg + LW'(push) - LW'(pop);
        remain      = level_reg - LW'(pop);
        rd_ptr_next = rd_ptr_reg + PW'(pop);
        wr_ptr_next = wr_ptr_reg + PW'(push);
        valid_next  = (level_next != '0);
        // Head after this edge: empty, bypass of the frame being pushed, or next stored entry.
        if (level_next == '0) begin
            frame_next = '0;
        end else if (remain == '0) begin
            frame_next = frame_in;
        end else begin
            frame_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= frame_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wcnt_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            frame_reg  <= '0;
            valid_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            wcnt_reg   <= wcnt_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            frame_reg  <= frame_next;
            valid_reg  <= valid_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign frame_o       = frame_reg;
    assign frame_valid_o = valid_reg;
    assign level_o       = level_reg;
    assign overflow_o    = ovf_reg;
endmodule

// File: tb/tb_timealign_frame_packer.sv
// Directed bench for timealign_frame_packer with a frame scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_timealign_frame_packer;
    localparam int W  = 6;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int FW = W * N;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [W-1:0]  din_i;
    logic          din_valid_i;
    logic          flush_i;
    logic [FW-1:0] frame_o;
    logic          frame_valid_o;
    logic          frame_ready_i;
    logic [2:0]    level_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    timealign_frame_packer #(.WORD_W(W), .WORDS_PER_FRAME(N), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .reset_i(reset_i), .din_i(din_i), .din_valid_i(din_valid_i),
        .flush_i(flush_i), .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i), .level_o(level_o), .overflow_o(overflow_o)
    );

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_q [$];
    logic [W-1:0]  mw [N-1];
    int            mwcnt  = 0;
    int            mlevel = 0;
    logic          movf   = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: update the model with the inputs now applied, clock, then compare.
    task automatic tick();
        logic mpop, complete, full;
        if (reset_i) begin
            exp_q.delete();
            mwcnt  = 0;
            mlevel = 0;
            movf   = 1'b0;
        end else begin
            mpop     = (mlevel > 0) && frame_ready_i;
            full     = (mlevel == D);
            complete = din_valid_i && !flush_i && (mwcnt == N - 1);
            if (mpop) begin
                void'(exp_q.pop_front());
                mlevel--;
            end
            if (complete) begin
                if (full && !mpop) movf = 1'b1;
                else begin
                    exp_q.push_back({mw[0], mw[1], mw[2], din_i});
                    mlevel++;
                end
            end
            if (flush_i) mwcnt = 0;
            else if (din_valid_i) begin
                if (mwcnt < N - 1) mw[mwcnt] = din_i;
                mwcnt = complete ? 0 : mwcnt + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("level", FW'(level_o), FW'(mlevel));
        chk("valid", FW'(frame_valid_o), FW'(mlevel != 0));
        chk("overflow", FW'(overflow_o), FW'(movf));
        chk("frame", frame_o, (exp_q.size() > 0) ? exp_q[0] : '0);
        $display("t=%0t din=%h dv=%b fl=%b rdy=%b -> frame=%h v=%b lvl=%0d ovf=%b",
                 $time, din_i, din_valid_i, flush_i, frame_ready_i, frame_o,
                 frame_valid_o, level_o, overflow_o);
    endtask

    task automatic send(input logic [W-1:0] w);
        din_i = w;
        din_valid_i = 1'b1;
        tick();
        din_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) send(base + W'(i));
    endtask

    initial begin
        reset_i = 1'b1; din_i = 6'h3F; din_valid_i = 1'b1; flush_i = 1'b0; frame_ready_i = 1'b0;
        @(negedge clk);

        // T1: reset held with valid words present
        repeat (3) tick();
        chk("t1_frame", frame_o, '0);
        chk("t1_level", FW'(level_o), '0);
        reset_i = 1'b0; din_valid_i = 1'b0;

        // T2: back-to-back words
        frame_ready_i = 1'b1;
        send(6'h01); send(6'h02); send(6'h03); send(6'h04);
        chk("t2_frame", frame_o, {6'h01, 6'h02, 6'h03, 6'h04});
        chk("t2_valid", FW'(frame_valid_o), FW'(1));
        tick();
        chk("t2_valid_1cyc", FW'(frame_valid_o), FW'(0));

        // T3: same words with gaps
        send(6'h01); tick(); tick(); send(6'h02); tick(); send(6'h03); tick(); tick(); send(6'h04);
        chk("t3_frame", frame_o, {6'h01, 6'h02, 6'h03, 6'h04});
        tick(); tick();
        chk("t3_no_extra", FW'(frame_valid_o), FW'(0));

        // T4: back-pressure, five frames into a four-deep FIFO
        frame_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(W'(6'h10 + 4 * k));
        chk("t4_level_full", FW'(level_o), FW'(4));
        chk("t4_head", frame_o, {6'h10, 6'h11, 6'h12, 6'h13});
        chk("t4_overflow", FW'(overflow_o), FW'(1));
        frame_ready_i = 1'b1;
        repeat (5) tick();
        chk("t4_drained", FW'(level_o), FW'(0));

        // T5: full FIFO, completing word coincides with a pop
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        frame_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(W'(6'h20 + 4 * k));
        send(6'h30); send(6'h31); send(6'h32);
        frame_ready_i = 1'b1;
        send(6'h33);
        chk("t5_level", FW'(level_o), FW'(4));
        chk("t5_no_ovf", FW'(overflow_o), FW'(0));
        chk("t5_head", frame_o, {6'h24, 6'h25, 6'h26, 6'h27});
        repeat (5) tick();

        // T6: flush discards the partial frame and the word presented with it
        send(6'h0A); send(6'h0B);
        din_i = 6'h15; din_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; din_valid_i = 1'b0;
        repeat (4) send(6'h3F);
        chk("t6_frame", frame_o, 24'hFFFFFF);
        tick();
        chk("t6_single", FW'(frame_valid_o), FW'(0));

        // T7: reset mid-frame
        send(6'h2A); send(6'h2A); send(6'h2A);
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        repeat (4) send(6'h05);
        chk("t7_frame", frame_o, {4{6'h05}});
        chk("t7_no_ovf", FW'(overflow_o), FW'(0));
        tick();
        chk("t7_single", FW'(frame_valid_o), FW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
